// File: rtl/alu_pkg.sv
// Shared ALU definitions: default data width and the 16 opcode encodings.
// Imported by the control unit and the ALU datapath.
package alu_pkg;

    localparam int DATA_WIDTH = 8;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_BEQ  = 4'hA;
    localparam logic [3:0] OP_BNE  = 4'hB;
    localparam logic [3:0] OP_BLTU = 4'hC;
    localparam logic [3:0] OP_MOV  = 4'hD;
    localparam logic [3:0] OP_INC  = 4'hE;
    localparam logic [3:0] OP_NOP  = 4'hF;

endpackage

// File: rtl/alu_datapath_mux2.sv
// Generic two-input selector used for operand, write-back and PC-step muxing.
module mux2
    import alu_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] out
);

    assign out = sel ? in1 : in0;

endmodule

// File: rtl/alu_datapath.sv
// ALU datapath: operand select, registered ALU core with carry/compare flags,
// write-back select and branch-dependent program-counter step.
module alu_datapath
    import alu_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] read_data1,
    input  logic [WIDTH-1:0] read_data2,
    input  logic [WIDTH-1:0] immediate,
    input  logic             alu_src,
    input  logic             load,
    input  logic             branch,
    input  logic [WIDTH-1:0] mem_read_data,
    output logic [WIDTH-1:0] alu_result,
    output logic             compare,
    output logic             carry,
    output logic [WIDTH-1:0] write_data,
    output logic [WIDTH-1:0] pc_increment
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(1);

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   inc;
    logic [WIDTH-1:0] res_n;
    logic             carry_n;
    logic             cmp_n;
    logic             taken;

    mux2 #(.WIDTH(WIDTH)) u_op_a (
        .sel (load),
        .in0 (read_data1),
        .in1 (immediate),
        .out (op_a)
    );

    mux2 #(.WIDTH(WIDTH)) u_op_b (
        .sel (alu_src),
        .in0 (read_data2),
        .in1 (immediate),
        .out (op_b)
    );

    // Bit WIDTH of diff is the unsigned borrow, shared by SUB and BLTU.
    assign sum  = {1'b0, op_a} + {1'b0, op_b};
    assign diff = {1'b0, op_a} - {1'b0, op_b};
    assign inc  = {1'b0, op_a} + (WIDTH + 1)'(1);

    always_comb begin
        res_n   = alu_result;
        carry_n = carry;
        cmp_n   = 1'b0;
        unique case (opcode)
            OP_ADD: begin
                res_n   = sum[WIDTH-1:0];
                carry_n = sum[WIDTH];
            end
            OP_SUB: begin
                res_n   = diff[WIDTH-1:0];
                carry_n = diff[WIDTH];
            end
            OP_AND:  res_n = op_a & op_b;
            OP_OR:   res_n = op_a | op_b;
            OP_XOR:  res_n = op_a ^ op_b;
            OP_NOT:  res_n = ~op_a;
            OP_SHL:  res_n = op_a << op_b[2:0];
            OP_SHR:  res_n = op_a >> op_b[2:0];
            OP_LD:   res_n = op_a;
            OP_ST:   res_n = op_a;
            OP_BEQ:  cmp_n = (op_a == op_b);
            OP_BNE:  cmp_n = (op_a != op_b);
            OP_BLTU: cmp_n = diff[WIDTH];
            OP_MOV:  res_n = op_b;
            OP_INC: begin
                res_n   = inc[WIDTH-1:0];
                carry_n = inc[WIDTH];
            end
            OP_NOP:  res_n = alu_result;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_result <= '0;
            compare    <= 1'b0;
            carry      <= 1'b0;
        end else begin
            alu_result <= res_n;
            compare    <= cmp_n;
            carry      <= carry_n;
        end
    end

    assign taken = branch & compare;

    mux2 #(.WIDTH(WIDTH)) u_wb (
        .sel (load),
        .in0 (alu_result),
        .in1 (mem_read_data),
        .out (write_data)
    );

    mux2 #(.WIDTH(WIDTH)) u_pc (
        .sel (taken),
        .in0 (STEP),
        .in1 (immediate),
        .out (pc_increment)
    );

endmodule

// File: tb/tb_alu_datapath.sv
// Self-checking bench for alu_datapath: arithmetic reference model checked
// every falling edge, plus hand-computed vectors for the key scenarios.
module tb_alu_datapath;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic [7:0] read_data1;
    logic [7:0] read_data2;
    logic [7:0] immediate;
    logic       alu_src;
    logic       load;
    logic       branch;
    logic [7:0] mem_read_data;
    logic [7:0] alu_result;
    logic       compare;
    logic       carry;
    logic [7:0] write_data;
    logic [7:0] pc_increment;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    int m_res   = 0;
    bit m_carry = 1'b0;
    bit m_cmp   = 1'b0;

    alu_datapath #(.WIDTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .read_data1    (read_data1),
        .read_data2    (read_data2),
        .immediate     (immediate),
        .alu_src       (alu_src),
        .load          (load),
        .branch        (branch),
        .mem_read_data (mem_read_data),
        .alu_result    (alu_result),
        .compare       (compare),
        .carry         (carry),
        .write_data    (write_data),
        .pc_increment  (pc_increment)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic modulo 256.
    always @(posedge clk or negedge rst) begin
        int a;
        int b;
        if (!rst) begin
            m_res   = 0;
            m_carry = 1'b0;
            m_cmp   = 1'b0;
        end else begin
            a = load ? int'(immediate) : int'(read_data1);
            b = alu_src ? int'(immediate) : int'(read_data2);
            m_cmp = 1'b0;
            case (int'(opcode))
                0: begin
                    m_res   = (a + b) % 256;
                    m_carry = (a + b) > 255;
                end
                1: begin
                    m_res   = (a - b + 256) % 256;
                    m_carry = a < b;
                end
                2:  m_res = a & b;
                3:  m_res = a | b;
                4:  m_res = a ^ b;
                5:  m_res = 255 - a;
                6:  m_res = (a * (1 << (b % 8))) % 256;
                7:  m_res = a / (1 << (b % 8));
                8:  m_res = a;
                9:  m_res = a;
                10: m_cmp = (a == b);
                11: m_cmp = (a != b);
                12: m_cmp = (a < b);
                13: m_res = b;
                14: begin
                    m_res   = (a + 1) % 256;
                    m_carry = (a == 255);
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("alu_result", int'(alu_result), m_res);
            check("carry", int'(carry), int'(m_carry));
            check("compare", int'(compare), int'(m_cmp));
            check("write_data", int'(write_data),
                  load ? int'(mem_read_data) : m_res);
            check("pc_increment", int'(pc_increment),
                  (branch && m_cmp) ? int'(immediate) : 1);
        end
    end

    task automatic apply(input logic [3:0] op, input logic [7:0] r1,
                         input logic [7:0] r2, input logic [7:0] im,
                         input logic src, input logic ld,
                         input logic br, input logic [7:0] mem);
        @(negedge clk);
        #1;
        opcode        = op;
        read_data1    = r1;
        read_data2    = r2;
        immediate     = im;
        alu_src       = src;
        load          = ld;
        branch        = br;
        mem_read_data = mem;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [7:0] va [4] = '{8'h3C, 8'h80, 8'h01, 8'h7F};
    logic [7:0] vb [4] = '{8'hA5, 8'h80, 8'hFE, 8'h02};

    initial begin
        rst = 1'b0;
        opcode = 4'hF;
        read_data1 = '0;
        read_data2 = '0;
        immediate = '0;
        alu_src = 1'b0;
        load = 1'b0;
        branch = 1'b0;
        mem_read_data = 8'h5A;
        repeat (2) @(posedge clk);
        #2;
        check("rst_result", int'(alu_result), 0);
        check("rst_pc", int'(pc_increment), 1);
        chk_en = 1'b1;
        apply(4'hF, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'hC3);
        #1;
        check("rst_wb_load", int'(write_data), 8'hC3);
        @(negedge clk);
        #3;
        rst = 1'b1;

        // Add with wrap-around and carry-out.
        apply(4'h0, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        check("add_res", int'(alu_result), 8'h00);
        check("add_carry", int'(carry), 1);
        check("add_cmp", int'(compare), 0);
        // Asynchronous reset between edges.
        rst = 1'b0;
        #1;
        check("arst_res", int'(alu_result), 0);
        check("arst_carry", int'(carry), 0);
        check("arst_cmp", int'(compare), 0);
        @(negedge clk);
        #3;
        rst = 1'b1;

        apply(4'h1, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        check("sub_res", int'(alu_result), 8'hFF);
        check("sub_borrow", int'(carry), 1);

        apply(4'hA, 8'h05, 8'h05, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        check("beq_cmp", int'(compare), 1);
        check("beq_hold", int'(alu_result), 8'hFF);
        branch = 1'b1;
        immediate = 8'h04;
        #1;
        check("br_taken_pc", int'(pc_increment), 8'h04);
        branch = 1'b0;
        #1;
        check("br_idle_pc", int'(pc_increment), 8'h01);

        apply(4'h8, 8'h00, 8'h00, 8'h10, 1'b0, 1'b1, 1'b0, 8'hAB);
        tick();
        check("ld_res", int'(alu_result), 8'h10);
        check("ld_wb", int'(write_data), 8'hAB);

        apply(4'h6, 8'h81, 8'h09, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        check("shl_res", int'(alu_result), 8'h02);
        apply(4'h7, 8'h81, 8'h09, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        check("shr_res", int'(alu_result), 8'h40);

        apply(4'hE, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        check("inc_res", int'(alu_result), 8'h00);
        check("inc_carry", int'(carry), 1);
        apply(4'h3, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        check("or_carry_hold", int'(carry), 1);

        // Reset pulse while a new operation is pending.
        apply(4'h0, 8'h10, 8'h20, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_res", int'(alu_result), 0);
        rst = 1'b1;
        tick();
        check("post_rst_add", int'(alu_result), 8'h30);

        // Sweep all opcodes across operand patterns; the model checks.
        for (int op = 0; op < 16; op++) begin
            for (int i = 0; i < 4; i++) begin
                apply(4'(op), va[i], vb[i], vb[3 - i], 1'(op + i),
                      1'(i == 2), 1'(i), 8'h96);
            end
        end
        apply(4'hC, 8'h01, 8'h02, 8'h33, 1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        check("bltu_pc", int'(pc_increment), 8'h33);
        apply(4'hB, 8'h07, 8'h07, 8'h44, 1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        check("bne_pc", int'(pc_increment), 8'h01);

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_datapath.md
ALU_DATAPATH -- requirements
Module: alu_datapath

Interface
REQ-001 Parameter WIDTH, default 8, data-path width; all data ports below use WIDTH.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 opcode  in  4  ALU operation select.
REQ-005 read_data1  in  8  register-file operand 1.
REQ-006 read_data2  in  8  register-file operand 2.
REQ-007 immediate  in  8  instruction immediate.
REQ-008 alu_src  in  1  1 = operand B from immediate, 0 = from read_data2.
REQ-009 load  in  1  1 = operand A from immediate and write-back from memory.
REQ-010 branch  in  1  branch-instruction strobe from control unit.
REQ-011 mem_read_data  in  8  data-memory read data.
REQ-012 alu_result  out  8  registered ALU result; also data-memory read address.
REQ-013 compare  out  1  registered branch-condition flag.
REQ-014 carry  out  1  registered carry/borrow flag.
REQ-015 write_data  out  8  register-file write-back data.
REQ-016 pc_increment  out  8  program-counter step.

Function
REQ-017 Operand A = load ? immediate : read_data1; operand B = alu_src ? immediate : read_data2; both combinational.
REQ-018 Opcodes: 0 ADD A+B; 1 SUB A-B; 2 AND; 3 OR; 4 XOR; 5 NOT A; 6 SHL A by B[2:0]; 7 SHR logical A by B[2:0]; 8 LD pass A; 9 ST pass A; A BEQ; B BNE; C BLTU; D MOV pass B; E INC A+1; F NOP.
REQ-019 alu_result registers the new value one clk edge after operands/opcode are presented (latency 1); opcodes A, B, C, F hold alu_result.
REQ-020 All arithmetic is modulo 2^8 (wrap-around); no saturation.
REQ-021 carry updates on ADD/INC (carry-out bit 8) and SUB (1 = borrow, A<B unsigned); held for all other opcodes.
REQ-022 compare updates every edge: BEQ -> A==B, BNE -> A!=B, BLTU -> A<B unsigned; all other opcodes -> 0.
REQ-023 Branch-taken = branch AND compare (combinational AND of input and registered flag).
REQ-024 pc_increment = branch-taken ? immediate : 8'd1, combinational.
REQ-025 write_data = load ? mem_read_data : alu_result, combinational.
REQ-026 Shift amount uses only B[2:0]; upper bits of B ignored for shifts.
REQ-027 No X propagation: unused opcode paths drive defined values; every case branch assigns all registers.

Reset
REQ-028 rst low asynchronously forces alu_result=0x00, compare=0, carry=0, regardless of clk.
REQ-029 While rst low, pc_increment=0x01 (compare=0) and write_data=load?mem_read_data:0x00.
REQ-030 Reset asserted mid-operation discards the in-flight result; first post-reset edge with rst high computes normally.

Structure
REQ-031 Shared package alu_pkg holds WIDTH default and the 16 opcode constants; used by control unit and this block.
REQ-032 One generic sub-module mux2 (WIDTH-parameterised, sel, in0, in1, out) instantiated for operand A, operand B, write-back and pc_increment selects; ALU core and AND gate inline.

Verification
REQ-033 ADD wrap: read_data1=0xFF, read_data2=0x01, alu_src=0, opcode=0, edge -> alu_result=0x00, carry=1, compare=0.
REQ-034 SUB borrow with immediate: read_data1=0x00, immediate=0x01, alu_src=1, opcode=1 -> alu_result=0xFF, carry=1.
REQ-035 Branch: read_data1=0x05, read_data2=0x05, opcode=A, edge, then branch=1, immediate=0x04 -> compare=1, pc_increment=0x04; branch=0 -> pc_increment=0x01.
REQ-036 Load: load=1, immediate=0x10, opcode=8, mem_read_data=0xAB -> after edge alu_result=0x10, write_data=0xAB.
REQ-037 Shift: read_data1=0x81, read_data2=0x09, opcode=6 -> alu_result=0x02 (amount 1); opcode=7 -> 0x40.
REQ-038 Async reset: after REQ-033 state, drop rst between edges -> alu_result=0x00, carry=0, compare=0 immediately, no clk edge required.
